ps2_frame_rx: RTL

//  Upstream stage of the PS/2 register peripheral: deserialises 11-bit PS/2 device->host frames
//  (start, 8 data LSB-first, odd parity, stop) from debounced ps2_clk/ps2_data lines.

---
 rtl/ps2_frame_rx.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/ps2_frame_rx.sv
// PS/2 device->host frame receiver: deserialises 11-bit frames, checks start/parity/stop,
// aborts stalled frames on timeout and buffers good bytes in a first-word-fall-through FIFO.
module ps2_frame_rx #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic [7:0]                    frame_data,
  output logic                          frame_valid,
  input  logic                          frame_ready,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          parity_err,
  output logic                          framing_err,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t          state;
  state_t          next_state;
  logic            ps2_clk_prev;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;
  logic            parity_bit;
  logic [TW-1:0]   tmo_cnt;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [7:0]      mem [FIFO_DEPTH];

  logic            fall;
  logic            pop;
  logic            full;
  logic            timeout;
  logic            push;
  logic            parity_err_next;
  logic            framing_err_next;
  logic            overflow_next;

  // Odd parity over data plus parity bit holds when the XOR of all nine bits is 1.
  function automatic logic parity_odd(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

  assign fall        = ps2_clk_prev & ~ps2_clk;
  assign frame_valid = (count != {CW{1'b0}});
  assign pop         = frame_valid & frame_ready;
  assign full        = (count == CW'(FIFO_DEPTH));
  assign timeout     = (state != IDLE) && !fall && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign frame_data  = mem[rd_ptr];

  // Next-state and frame verdict; the stop-bit fall decides exactly one of drop/push.
  always_comb begin
    next_state       = state;
    push             = 1'b0;
    parity_err_next  = 1'b0;
    framing_err_next = 1'b0;
    overflow_next    = 1'b0;
    if (fall) begin
      case (state)
        IDLE: begin
          if (!ps2_data) next_state = DATA;
          else           next_state = IDLE;
        end
        DATA: begin
          if (bit_cnt == 3'd7) next_state = PARITY;
          else                 next_state = DATA;
        end
        PARITY: next_state = STOP;
        STOP: begin
          next_state = IDLE;
          if (!ps2_data)                           framing_err_next = 1'b1;
          else if (!parity_odd(shift, parity_bit)) parity_err_next  = 1'b1;
          else if (full && !pop)                   overflow_next    = 1'b1;
          else                                     push             = 1'b1;
        end
        default: next_state = IDLE;
      endcase
    end else if (timeout) begin
      next_state       = IDLE;
      framing_err_next = 1'b1;
    end else begin
      next_state = state;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Edge detector, bit shifter and inter-edge timeout counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      ps2_clk_prev <= 1'b1;
      bit_cnt      <= 3'd0;
      shift        <= 8'd0;
      parity_bit   <= 1'b0;
      tmo_cnt      <= {TW{1'b0}};
    end else begin
      ps2_clk_prev <= ps2_clk;
      if (fall) begin
        case (state)
          IDLE:   bit_cnt <= 3'd0;
          DATA: begin
            shift[bit_cnt] <= ps2_data;
            bit_cnt        <= bit_cnt + 3'd1;
          end
          PARITY: parity_bit <= ps2_data;
          default: bit_cnt <= bit_cnt;
        endcase
      end
      if (fall || state == IDLE || timeout) tmo_cnt <= {TW{1'b0}};
      else                                  tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  // Registered error pulses, one cycle after the deciding edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      parity_err  <= parity_err_next;
      framing_err <= framing_err_next;
      overflow    <= overflow_next;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {CW{1'b0}};
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shift;
  end

endmodule
